// File: rtl/aes_pkg.sv
// Shared AES constants, types and inverse-round helpers used by the decipher datapath.
package aes_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned ROUND_W = 4;

    localparam logic               KEYLEN_128 = 1'b0;
    localparam logic               KEYLEN_256 = 1'b1;
    localparam logic [ROUND_W-1:0] NR_128     = 4'ha;
    localparam logic [ROUND_W-1:0] NR_256     = 4'he;

    typedef logic [WORD_W-1:0]  aes_word_t;
    typedef logic [BLOCK_W-1:0] aes_block_t;

    function automatic logic [7:0] gm2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm4(input logic [7:0] x);
        return gm2(gm2(x));
    endfunction

    function automatic logic [7:0] gm8(input logic [7:0] x);
        return gm2(gm4(x));
    endfunction

    function automatic logic [7:0] gm09(input logic [7:0] x);
        return gm8(x) ^ x;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] x);
        return gm8(x) ^ gm2(x) ^ x;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] x);
        return gm8(x) ^ gm4(x) ^ x;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] x);
        return gm8(x) ^ gm4(x) ^ gm2(x);
    endfunction

    function automatic aes_word_t inv_mix_word(input aes_word_t w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm09(a3),
                gm09(a0) ^ gm14(a1) ^ gm11(a2) ^ gm13(a3),
                gm13(a0) ^ gm09(a1) ^ gm14(a2) ^ gm11(a3),
                gm11(a0) ^ gm13(a1) ^ gm09(a2) ^ gm14(a3)};
    endfunction

    function automatic aes_block_t inv_mix_columns(input aes_block_t b);
        return {inv_mix_word(b[127:96]), inv_mix_word(b[95:64]),
                inv_mix_word(b[63:32]),  inv_mix_word(b[31:0])};
    endfunction

    // Row r of every column is taken from column (c - r) mod 4.
    function automatic aes_block_t inv_shift_rows(input aes_block_t b);
        aes_word_t w0, w1, w2, w3;
        w0 = b[127:96];
        w1 = b[95:64];
        w2 = b[63:32];
        w3 = b[31:0];
        return {{w0[31:24], w3[23:16], w2[15:8], w1[7:0]},
                {w1[31:24], w0[23:16], w3[15:8], w2[7:0]},
                {w2[31:24], w1[23:16], w0[15:8], w3[7:0]},
                {w3[31:24], w2[23:16], w1[15:8], w0[7:0]}};
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational 32-bit inverse S-box: four parallel byte lookups.
module aes_inv_sbox (
    input  logic [31:0] sword,
    output logic [31:0] new_sword
);

    // Entry i lives at bits [2047 - 8*i -: 8].
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // 2047 - 8*b equals {~b, 3'b111}.
    function automatic logic [7:0] inv_sub(input logic [7:0] b);
        return INV_SBOX_TBL[{~b, 3'b111} -: 8];
    endfunction

    assign new_sword = {inv_sub(sword[31:24]), inv_sub(sword[23:16]),
                        inv_sub(sword[15:8]),  inv_sub(sword[7:0])};

endmodule

// File: rtl/aes_decipher_ctrl.sv
// Iterative AES decipher: sequences inverse rounds over a shared 32-bit inverse S-box
// and addresses the external round-key store with the round counter.
module aes_decipher_ctrl
    import aes_pkg::*;
#(
    parameter logic       AES_128_BIT_KEY = KEYLEN_128,
    parameter logic       AES_256_BIT_KEY = KEYLEN_256,
    parameter logic [3:0] AES128_ROUNDS   = NR_128,
    parameter logic [3:0] AES256_ROUNDS   = NR_256
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round_key_addr,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_SBOX  = 3'd3,
        ST_MIX   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    aes_block_t           block_q, block_d;
    logic [ROUND_W-1:0]   round_ctr_q, round_ctr_d;
    logic [1:0]           sword_ctr_q, sword_ctr_d;
    logic                 keylen_q, keylen_d;
    logic                 ready_q, ready_d;
    aes_word_t            sbox_in, sbox_out;

    // Colliding encodings fall back to the 128-bit schedule.
    function automatic logic [ROUND_W-1:0] rounds_for(input logic kl);
        if ((kl == AES_256_BIT_KEY) && (kl != AES_128_BIT_KEY)) begin
            return AES256_ROUNDS;
        end
        return AES128_ROUNDS;
    endfunction

    aes_inv_sbox u_inv_sbox (
        .sword     (sbox_in),
        .new_sword (sbox_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (next) state_d = ST_INIT;
            ST_INIT:  state_d = ST_SHIFT;
            ST_SHIFT: state_d = ST_SBOX;
            ST_SBOX:  if (sword_ctr_q == 2'd3) state_d = ST_MIX;
            ST_MIX:   state_d = (round_ctr_q == '0) ? ST_IDLE : ST_SHIFT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (sword_ctr_q)
            2'd0:    sbox_in = block_q[127:96];
            2'd1:    sbox_in = block_q[95:64];
            2'd2:    sbox_in = block_q[63:32];
            default: sbox_in = block_q[31:0];
        endcase
    end

    // Datapath and counter updates for the current state.
    always_comb begin
        block_d     = block_q;
        round_ctr_d = round_ctr_q;
        sword_ctr_d = sword_ctr_q;
        keylen_d    = keylen_q;
        ready_d     = ready_q;
        case (state_q)
            ST_IDLE: begin
                if (next) begin
                    keylen_d    = keylen;
                    block_d     = block;
                    round_ctr_d = rounds_for(keylen);
                    ready_d     = 1'b0;
                end
            end
            ST_INIT: begin
                block_d     = block_q ^ round_key;
                round_ctr_d = rounds_for(keylen_q) - 4'd1;
            end
            ST_SHIFT: begin
                block_d     = inv_shift_rows(block_q);
                sword_ctr_d = 2'd0;
            end
            ST_SBOX: begin
                case (sword_ctr_q)
                    2'd0:    block_d[127:96] = sbox_out;
                    2'd1:    block_d[95:64]  = sbox_out;
                    2'd2:    block_d[63:32]  = sbox_out;
                    default: block_d[31:0]   = sbox_out;
                endcase
                sword_ctr_d = sword_ctr_q + 2'd1;
            end
            ST_MIX: begin
                if (round_ctr_q != '0) begin
                    block_d     = inv_mix_columns(block_q ^ round_key);
                    round_ctr_d = round_ctr_q - 4'd1;
                end else begin
                    block_d = block_q ^ round_key;
                    ready_d = 1'b1;
                end
            end
            default: begin
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            block_q     <= '0;
            round_ctr_q <= '0;
            sword_ctr_q <= '0;
            keylen_q    <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            block_q     <= block_d;
            round_ctr_q <= round_ctr_d;
            sword_ctr_q <= sword_ctr_d;
            keylen_q    <= keylen_d;
            ready_q     <= ready_d;
        end
    end

    assign round_key_addr = round_ctr_q;
    assign new_block      = block_q;
    assign ready          = ready_q;

endmodule

// File: tb/tb_aes_decipher_ctrl.sv
// Directed bench for aes_decipher_ctrl using FIPS-197 C.1/C.3 vectors and a key-expansion model.
module tb_aes_decipher_ctrl;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk;
    logic         reset_n;
    logic         next;
    logic         keylen;
    logic [3:0]   round_key_addr;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    logic [127:0] rk [16];
    logic [7:0]   sbox_tbl [256];
    int           errors = 0;
    int           checks = 0;

    assign round_key = rk[round_key_addr];

    aes_decipher_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .next           (next),
        .keylen         (keylen),
        .round_key_addr (round_key_addr),
        .round_key      (round_key),
        .block          (block),
        .new_block      (new_block),
        .ready          (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox_tbl[x[31:24]], sbox_tbl[x[23:16]], sbox_tbl[x[15:8]], sbox_tbl[x[7:0]]};
    endfunction

    // Forward S-box from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_tbl[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [255:0] key, input logic kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nk;
        int          nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk[r] = 128'h0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic kl, input logic [127:0] blk);
        next   = 1'b1;
        keylen = kl;
        block  = blk;
        tick();
        next   = 1'b0;
    endtask

    task automatic wait_ready(input int start, input int limit, output int lat);
        lat = start;
        while (ready !== 1'b1 && lat < limit) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        next    = 1'b0;
        keylen  = 1'b0;
        block   = 128'h0;
        tick();
        tick();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", ready);
        end
        checks++;
        if (new_block !== 128'h0) begin
            errors++;
            $display("FAIL reset_new_block: got %h expected 0", new_block);
        end
        checks++;
        if (round_key_addr !== 4'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 0", round_key_addr);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_aes128();
        int lat;
        expand_key(KEY128, 1'b0);
        start_run(1'b0, CT128);
        block = 128'hdeadbeef;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL aes128_accept: ready got %b expected 0", ready);
        end
        wait_ready(0, 200, lat);
        checks++;
        if (lat !== 61) begin
            errors++;
            $display("FAIL aes128_latency: got %0d expected 61", lat);
        end
        checks++;
        if (new_block !== PT) begin
            errors++;
            $display("FAIL aes128_result: got %h expected %h", new_block, PT);
        end
        repeat (3) tick();
        checks++;
        if (new_block !== PT || ready !== 1'b1) begin
            errors++;
            $display("FAIL aes128_hold: got %h ready %b expected %h ready 1", new_block, ready, PT);
        end
    endtask

    task automatic test_aes256();
        int lat;
        expand_key(KEY256, 1'b1);
        start_run(1'b1, CT256);
        wait_ready(0, 200, lat);
        checks++;
        if (lat !== 85) begin
            errors++;
            $display("FAIL aes256_latency: got %0d expected 85", lat);
        end
        checks++;
        if (new_block !== PT) begin
            errors++;
            $display("FAIL aes256_result: got %h expected %h", new_block, PT);
        end
    endtask

    task automatic test_addr_trace();
        expand_key(KEY128, 1'b0);
        start_run(1'b0, CT128);
        checks++;
        if (round_key_addr !== 4'd10) begin
            errors++;
            $display("FAIL addr_init: got %0d expected 10", round_key_addr);
        end
        for (int r = 9; r >= 0; r--) begin
            for (int j = 0; j < 6; j++) begin
                tick();
                checks++;
                if (round_key_addr !== 4'(r)) begin
                    errors++;
                    $display("FAIL addr_trace r=%0d j=%0d: got %0d expected %0d", r, j, round_key_addr, r);
                end
            end
        end
        tick();
        checks++;
        if (ready !== 1'b1 || new_block !== PT) begin
            errors++;
            $display("FAIL addr_trace_done: ready %b block %h expected ready 1 block %h", ready, new_block, PT);
        end
    endtask

    task automatic test_ignore_next();
        int lat;
        expand_key(KEY128, 1'b0);
        start_run(1'b0, CT128);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            keylen = ~keylen;
            tick();
            lat++;
        end
        next   = 1'b1;
        block  = CT256;
        keylen = 1'b1;
        tick();
        lat++;
        next   = 1'b0;
        block  = 128'h0123456789abcdef0123456789abcdef;
        while (lat < 60) begin
            keylen = ~keylen;
            tick();
            lat++;
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy_ready: got %b expected 0 at cycle 60", ready);
        end
        next = 1'b1;
        tick();
        next = 1'b0;
        checks++;
        if (ready !== 1'b1 || new_block !== PT) begin
            errors++;
            $display("FAIL ignore_result: ready %b block %h expected ready 1 block %h", ready, new_block, PT);
        end
        tick();
        checks++;
        if (ready !== 1'b1 || new_block !== PT) begin
            errors++;
            $display("FAIL ignore_completion_next: ready %b block %h expected ready 1 block %h", ready, new_block, PT);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        expand_key(KEY128, 1'b0);
        start_run(1'b0, CT128);
        repeat (30) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || new_block !== 128'h0 || round_key_addr !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid: ready %b block %h addr %0d expected ready 1 block 0 addr 0",
                     ready, new_block, round_key_addr);
        end
        tick();
        reset_n = 1'b1;
        tick();
        start_run(1'b0, CT128);
        wait_ready(0, 200, lat);
        checks++;
        if (lat !== 61 || new_block !== PT) begin
            errors++;
            $display("FAIL reset_rerun: lat %0d block %h expected lat 61 block %h", lat, new_block, PT);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        expand_key(KEY128, 1'b0);
        start_run(1'b0, CT128);
        wait_ready(0, 200, lat);
        checks++;
        if (lat !== 61 || new_block !== PT) begin
            errors++;
            $display("FAIL b2b_first: lat %0d block %h expected lat 61 block %h", lat, new_block, PT);
        end
        expand_key(KEY256, 1'b1);
        start_run(1'b1, CT256);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: ready got %b expected 0", ready);
        end
        wait_ready(0, 200, lat);
        checks++;
        if (lat !== 85 || new_block !== PT) begin
            errors++;
            $display("FAIL b2b_second: lat %0d block %h expected lat 85 block %h", lat, new_block, PT);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        test_reset();
        test_aes128();
        test_aes256();
        test_addr_trace();
        test_ignore_next();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
